// File: rtl/counter_snapshot_cdc_if.sv
`timescale 1ns/1ps
// counter_snapshot_cdc_if: clk_dst-domain request/result bundle of counter_snapshot_cdc.
// master drives trig and consumes snapshots; slave is the snapshot engine.
interface counter_snapshot_cdc_if #(
  parameter int unsigned WIDTH = 64
);
  logic             trig;
  logic             busy;
  logic             snap_valid;
  logic [WIDTH-1:0] snap;
  logic [WIDTH-1:0] snap_delta;
  logic             trig_missed;
  logic             mono_err;

  modport master (
    output trig,
    input  busy, snap_valid, snap, snap_delta, trig_missed, mono_err
  );

  modport slave (
    input  trig,
    output busy, snap_valid, snap, snap_delta, trig_missed, mono_err
  );
endinterface

// File: rtl/counter_snapshot_cdc.sv
`timescale 1ns/1ps
// counter_snapshot_cdc: coherent snapshots of a src_clk-domain counter via a 4-phase req/ack
// handshake, started by a periodic timer or trig. Optional SNAP_MONO_CHECK_EN flags backward snaps.
module counter_snapshot_cdc #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned PERIOD = 1024
) (
  input  logic                   clk_dst,
  input  logic                   aresetn,
  input  logic                   i_src_clk,
  input  logic                   i_src_rst,
  input  logic [WIDTH-1:0]       i_src_cnt,
  counter_snapshot_cdc_if.slave  snap_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // ---------------------------------------------------------------- source domain
  logic [STAGES-1:0] r_req_sync;
  logic              r_ack;
  logic [WIDTH-1:0]  r_hold_src;
  logic              w_req_s;
  logic              r_req;

  assign w_req_s = r_req_sync[STAGES-1];

  // req synchroniser is left unreset so a src_rst mid-handshake re-raises ack from the live req
  always_ff @(posedge i_src_clk) begin
    r_req_sync <= {r_req_sync[STAGES-2:0], r_req};
  end

  // hold_src freezes once ack is up, so the destination may sample it as a whole word
  always_ff @(posedge i_src_clk) begin
    if (i_src_rst) begin
      r_ack      <= 1'b0;
      r_hold_src <= '0;
    end else begin
      r_ack <= w_req_s;
      if (w_req_s && !r_ack) begin
        r_hold_src <= i_src_cnt;
      end
    end
  end

  // ---------------------------------------------------------------- destination domain
  logic [STAGES-1:0] r_ack_sync;
  logic              w_ack_d;

  // unreset on purpose: a stale ack must stay visible across aresetn to block a torn capture
  always_ff @(posedge clk_dst) begin
    r_ack_sync <= {r_ack_sync[STAGES-2:0], r_ack};
  end

  assign w_ack_d = r_ack_sync[STAGES-1];

  logic w_tick;

  generate
    if (PERIOD > 0) begin : g_timer
      localparam int unsigned TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
      localparam logic [TW-1:0] RELOAD = TW'(PERIOD - 1);
      logic [TW-1:0] r_timer;

      always_ff @(posedge clk_dst) begin
        if (!aresetn) begin
          r_timer <= RELOAD;
        end else if (r_timer == '0) begin
          r_timer <= RELOAD;
        end else begin
          r_timer <= r_timer - TW'(1);
        end
      end

      assign w_tick = (r_timer == '0);
    end else begin : g_no_timer
      assign w_tick = 1'b0;
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pending;
  logic             r_busy;
  logic             r_snap_valid;
  logic             r_trig_missed;
  logic [WIDTH-1:0] r_hold_dst;
  logic [WIDTH-1:0] r_snap;
  logic [WIDTH-1:0] r_snap_delta;

  logic             w_start;
  logic             w_req_nxt;
  logic             w_pending_nxt;
  logic             w_valid_nxt;
  logic             w_missed_nxt;
  logic [WIDTH-1:0] w_hold_dst_nxt;
  logic [WIDTH-1:0] w_snap_nxt;
  logic [WIDTH-1:0] w_delta_nxt;

  assign w_start = w_tick | snap_if.trig;

  // next-state and next-register values
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_pending_nxt  = r_pending;
    w_valid_nxt    = 1'b0;
    w_missed_nxt   = 1'b0;
    w_hold_dst_nxt = r_hold_dst;
    w_snap_nxt     = r_snap;
    w_delta_nxt    = r_snap_delta;

    if (r_state != ST_IDLE) begin
      if (snap_if.trig && r_pending) begin
        w_missed_nxt = 1'b1;
      end else if (w_start) begin
        w_pending_nxt = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if ((w_start || r_pending) && !w_ack_d) begin
          w_req_nxt     = 1'b1;
          w_pending_nxt = 1'b0;
          w_state_nxt   = ST_REQ;
        end else if (w_start) begin
          w_pending_nxt = 1'b1;
        end
      end
      ST_REQ: begin
        if (w_ack_d) begin
          w_hold_dst_nxt = r_hold_src;
          w_req_nxt      = 1'b0;
          w_state_nxt    = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!w_ack_d) begin
          w_snap_nxt  = r_hold_dst;
          w_delta_nxt = r_hold_dst - r_snap;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_dst) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_req         <= 1'b0;
      r_pending     <= 1'b0;
      r_busy        <= 1'b0;
      r_snap_valid  <= 1'b0;
      r_trig_missed <= 1'b0;
      r_hold_dst    <= '0;
      r_snap        <= '0;
      r_snap_delta  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_req         <= w_req_nxt;
      r_pending     <= w_pending_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_snap_valid  <= w_valid_nxt;
      r_trig_missed <= w_missed_nxt;
      r_hold_dst    <= w_hold_dst_nxt;
      r_snap        <= w_snap_nxt;
      r_snap_delta  <= w_delta_nxt;
    end
  end

`ifdef SNAP_MONO_CHECK_EN
  logic r_has_snap;
  logic r_mono_err;

  // a snap below its predecessor means the counter was reset or wrapped
  always_ff @(posedge clk_dst) begin
    if (!aresetn) begin
      r_has_snap <= 1'b0;
      r_mono_err <= 1'b0;
    end else begin
      r_mono_err <= w_valid_nxt && r_has_snap && (r_hold_dst < r_snap);
      if (w_valid_nxt) begin
        r_has_snap <= 1'b1;
      end
    end
  end

  assign snap_if.mono_err = r_mono_err;
`else
  assign snap_if.mono_err = 1'b0;
`endif

  assign snap_if.busy        = r_busy;
  assign snap_if.snap_valid  = r_snap_valid;
  assign snap_if.snap        = r_snap;
  assign snap_if.snap_delta  = r_snap_delta;
  assign snap_if.trig_missed = r_trig_missed;

endmodule
